// File: rtl/image_loader_mk1_if.sv
// Byte-stream handshake from the host source into the image loader.
// The master drives pixel bytes and frame sideband. The slave returns ready.
interface image_loader_mk1_if;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       SOF;
  logic       DIN_READY;

  modport master (output DIN, output DIN_VALID, output SOF, input DIN_READY);
  modport slave  (input DIN, input DIN_VALID, input SOF, output DIN_READY);
endinterface

// File: rtl/image_loader_mk1.sv
// Image loader: packs a 1-bit-per-pixel byte stream into REDUCED_PIXELS-wide line
// words and writes one word per line into the frame image memory.
module image_loader_mk1 #(
  parameter int REDUCED_PIXELS = 19,
  parameter int REDUCED_LINES  = 10,
  parameter int ADDR_W         = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  image_loader_mk1_if.slave         s,
  output logic                      MEM_WE,
  output logic [ADDR_W-1:0]         MEM_ADDR,
  output logic [REDUCED_PIXELS-1:0] MEM_DATA,
  output logic                      BUSY,
  output logic                      FRAME_DONE
);
  localparam int PW = $clog2(REDUCED_PIXELS + 1);
  localparam int LW = (REDUCED_LINES > 1) ? $clog2(REDUCED_LINES) : 1;
  localparam int SW = PW + 4;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [LW-1:0]             line_q, line_d;
  logic [PW-1:0]             pix_cnt_q, pix_cnt_d;
  logic [REDUCED_PIXELS-1:0] line_buf_q, line_buf_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [REDUCED_PIXELS-1:0] mem_data_q, mem_data_d;

  logic                      xfer, restart, load, full, last_line;
  logic [PW-1:0]             base;
  logic [SW-1:0]             sum;
  logic [REDUCED_PIXELS-1:0] merged;
  int                        idx;

  assign s.DIN_READY = (state_q != WRITE);
  assign xfer        = s.DIN_VALID && s.DIN_READY;
  assign restart     = xfer && s.SOF;
  assign load        = restart || (xfer && state_q == FILL);
  assign last_line   = (line_q == LW'(REDUCED_LINES - 1));

  // Merge the incoming byte into the line; an SOF byte always starts a fresh line 0.
  always_comb begin
    base   = restart ? '0 : pix_cnt_q;
    merged = restart ? '0 : line_buf_q;
    idx    = 0;
    for (int k = 0; k < 8; k++) begin
      idx = int'(base) + k;
      if (idx < REDUCED_PIXELS) merged[idx] = s.DIN[k];
    end
    sum  = SW'(base) + SW'(8);
    full = (sum >= SW'(REDUCED_PIXELS));
  end

  // Next-state logic: IDLE waits for SOF, FILL packs bytes, WRITE emits one line.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    pix_cnt_d  = pix_cnt_q;
    line_buf_d = line_buf_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE, FILL: begin
        if (load) begin
          line_buf_d = merged;
          pix_cnt_d  = full ? PW'(REDUCED_PIXELS) : sum[PW-1:0];
          if (restart) line_d = '0;
          state_d    = full ? WRITE : FILL;
        end
      end
      WRITE: begin
        line_buf_d = '0;
        pix_cnt_d  = '0;
        mem_addr_d = ADDR_W'(line_q);
        mem_data_d = line_buf_q;
        if (last_line) begin
          line_d  = '0;
          state_d = IDLE;
        end else begin
          line_d  = line_q + LW'(1);
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      line_q     <= '0;
      pix_cnt_q  <= '0;
      line_buf_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      pix_cnt_q  <= pix_cnt_d;
      line_buf_q <= line_buf_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Memory port presents the current line during WRITE and holds the last write otherwise.
  always_comb begin
    MEM_WE     = (state_q == WRITE);
    MEM_ADDR   = MEM_WE ? ADDR_W'(line_q) : mem_addr_q;
    MEM_DATA   = MEM_WE ? line_buf_q : mem_data_q;
    FRAME_DONE = MEM_WE && last_line;
    BUSY       = (state_q != IDLE);
  end
endmodule

// File: tb/tb_image_loader_mk1.sv
// Bench for image_loader_mk1: directed scenarios plus random frames, every cycle
// compared against a bit-queue model of the pixel stream.
module tb_image_loader_mk1;
  localparam int RP = 19;
  localparam int RL = 10;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          MEM_WE, BUSY, FRAME_DONE;
  logic [AW-1:0] MEM_ADDR;
  logic [RP-1:0] MEM_DATA;

  image_loader_mk1_if s_if ();

  image_loader_mk1 #(.REDUCED_PIXELS(RP), .REDUCED_LINES(RL), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .s(s_if.slave),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a stream of pixels; every RP pixels (rounded up to a
  // whole byte) form one line, excess bits of the last byte are dropped.
  bit            pix[$];
  bit            in_frame = 0;
  int            line = 0;
  bit            due = 0, due_last = 0;
  logic [AW-1:0] due_addr = '0, last_addr = '0;
  logic [RP-1:0] due_data = '0, last_data = '0;

  always @(negedge CLK) begin
    logic [RP-1:0] word;
    bit            rdy;
    if (due) begin
      last_addr = due_addr;
      last_data = due_data;
      writes_seen++;
    end
    chk("mem_we", 32'(MEM_WE), 32'(due));
    chk("din_ready", 32'(s_if.DIN_READY), 32'(!due));
    chk("busy", 32'(BUSY), 32'(in_frame || due));
    chk("frame_done", 32'(FRAME_DONE), 32'(due && due_last));
    chk("mem_addr", 32'(MEM_ADDR), 32'(last_addr));
    chk("mem_data", 32'(MEM_DATA), 32'(last_data));
    rdy = !due;
    due = 0;
    if (RESET) begin
      in_frame  = 0;
      line      = 0;
      pix.delete();
      last_addr = '0;
      last_data = '0;
    end else if (s_if.DIN_VALID && rdy) begin
      if (s_if.SOF) begin
        in_frame = 1;
        line     = 0;
        pix.delete();
      end
      if (in_frame) begin
        for (int k = 0; k < 8; k++) pix.push_back(s_if.DIN[k]);
        if (pix.size() >= RP) begin
          for (int p = 0; p < RP; p++) word[p] = pix[p];
          due      = 1;
          due_addr = AW'(line);
          due_data = word;
          due_last = (line == RL - 1);
          pix.delete();
          if (due_last) begin
            in_frame = 0;
            line     = 0;
          end else line++;
        end
      end
    end
  end

  // Present one byte and hold it until the handshake completes.
  task automatic send(input logic [7:0] d, input bit sof);
    bit r;
    int n = 0;
    s_if.DIN       = d;
    s_if.SOF       = sof;
    s_if.DIN_VALID = 1'b1;
    do begin
      @(negedge CLK);
      r = s_if.DIN_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) chk("handshake_timeout", 32'(n), 32'(0));
    s_if.DIN_VALID = 1'b0;
    s_if.SOF       = 1'b0;
  endtask

  task automatic idle(input int n);
    s_if.DIN_VALID = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    s_if.DIN_VALID = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  // Three-byte line, SOF optionally on its first byte.
  task automatic send_line(input logic [7:0] b0, b1, b2, input bit sof);
    send(b0, sof);
    send(b1, 1'b0);
    send(b2, 1'b0);
  endtask

  initial begin
    int w0;
    s_if.DIN = '0; s_if.DIN_VALID = 1'b0; s_if.SOF = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle(2);

    // Full frame of all-ones lines, valid never dropped.
    w0 = writes_seen;
    for (int l = 0; l < RL; l++) send_line(8'hFF, 8'hFF, 8'h07, l == 0);
    idle(3);
    chk("frame1_writes", 32'(writes_seen - w0), 32'(RL));

    // Edge bits of the line and discarded tail bits.
    for (int l = 0; l < RL; l++)
      if (l[0]) send_line(8'h00, 8'h00, 8'hFC, 1'b0);
      else      send_line(8'h01, 8'h00, 8'h04, l == 0);
    idle(3);

    // Stray bytes in IDLE are swallowed.
    w0 = writes_seen;
    for (int i = 0; i < 5; i++) send(8'(i * 37 + 1), 1'b0);
    idle(2);
    chk("idle_no_write", 32'(writes_seen - w0), 32'(0));

    // SOF mid-line abandons the partial line.
    for (int l = 0; l < 4; l++) send_line(8'(l + 1), 8'hA5, 8'h3C, l == 0);
    send(8'h55, 1'b0);
    for (int l = 0; l < RL; l++) send_line(8'h5A, 8'(l), 8'h02, l == 0);
    idle(2);

    // Reset mid-frame, then a clean frame.
    for (int l = 0; l < 3; l++) send_line(8'hC3, 8'h81, 8'h05, l == 0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    w0 = writes_seen;
    do_reset();
    idle(2);
    chk("reset_no_write", 32'(writes_seen - w0), 32'(0));
    for (int l = 0; l < RL; l++) send_line(8'hF0, 8'h0F, 8'h06, l == 0);
    idle(2);

    // Random frames with gaps, stray SOFs and pre-SOF junk.
    for (int f = 0; f < 6; f++) begin
      send(8'($urandom), 1'b0);
      send(8'($urandom), 1'b1);
      for (int b = 1; b < RL * 3; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(8'($urandom), ($urandom_range(0, 60) == 0));
      end
      idle(4);
    end

    idle(4);
    chk("model_idle_at_end", 32'(in_frame), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
